// File: rtl/transceiver_pkg.sv
// Shared framing definitions for the piso/sipo serial link.
// Latency: none (types and constants only).
// Backpressure: none.
package transceiver_pkg;

    // Receiver FSM state encoding, shared so both ends agree on naming.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP  = 2'd2,
        ST_BREAK = 2'd3
    } rx_state_e;

    // Line-level framing constants.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register for received words, with overrun detect.
// Latency: 1 clk from commit strobe to out_valid/y.
// Backpressure: a commit while full and not being drained is dropped and flagged by ovr_err.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   commit_vld/_dat   good-frame strobe and its word (single cycle)
//   out_ready         consumer accepts y when out_valid && out_ready
//   y, out_valid      held word and its valid flag
//   ovr_err           registered one-cycle pulse on a dropped commit
module sipo_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         commit_vld,
    input  logic [W-1:0] commit_dat,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         out_valid,
    output logic         ovr_err
);

    logic [W-1:0] y_q, y_d;
    logic         vld_q, vld_d;
    logic         ovr_q, ovr_d;
    logic         accept;

    // A word may be loaded when empty, or when the current word leaves this same cycle.
    assign accept = commit_vld && (!vld_q || out_ready);

    always_comb begin
        y_d   = y_q;
        vld_d = vld_q;
        ovr_d = commit_vld && vld_q && !out_ready;
        if (accept) begin
            y_d   = commit_dat;
            vld_d = 1'b1;
        end else if (vld_q && out_ready) begin
            // Drained with nothing new: y keeps its last value.
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign y         = y_q;
    assign out_valid = vld_q;
    assign ovr_err   = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: start/stop framed, MSB-first, sampled on en strobes.
// Latency: 1 clk from the stop-bit sample edge to out_valid.
// Backpressure: one-entry output register; a word completing while it is full and undrained is dropped (ovr_err).
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en, z           bit-sample strobe and serial line (idle high)
//   y, out_valid    received word [DATA_WIDTH-1:1] and its valid flag
//   out_ready       consumer handshake
//   frm_err         one-cycle pulse: stop bit sampled as 0
//   ovr_err         one-cycle pulse: word dropped on a full output register
module sipo_rx
    import transceiver_pkg::*;
#(
    parameter int DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  z,
    output logic [DATA_WIDTH-1:1] y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frm_err,
    output logic                  ovr_err
);

    localparam int NB = DATA_WIDTH - 1;          // data bits per frame
    localparam int CW = $clog2(DATA_WIDTH);      // counter width
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NB-1:0]     shift_q, shift_d;
    logic              frm_err_q, frm_err_d;
    logic              commit_vld;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        frm_err_d  = 1'b0;
        commit_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (z == START_BIT)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (en) begin
                    // Shift in at the LSB so the first data bit ends up at the MSB.
                    shift_d = {shift_q[NB-2:0], z};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (en) begin
                    if (z == STOP_BIT) begin
                        commit_vld = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frm_err_d = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before a new start bit counts.
                if (en && (z == IDLE_LEVEL)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign frm_err = frm_err_q;

    sipo_out_reg #(
        .W(NB)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .commit_vld (commit_vld),
        .commit_dat (shift_d),
        .out_ready  (out_ready),
        .y          (y),
        .out_valid  (out_valid),
        .ovr_err    (ovr_err)
    );

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       z;
    logic [8:1] y;
    logic       out_valid;
    logic       out_ready;
    logic       frm_err;
    logic       ovr_err;

    int n_cmp;
    int n_mis;

    sipo_rx #(.DATA_WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Hold z for gap idle cycles plus one strobe cycle; returns #1 after the strobe edge.
    task automatic send_bit(input logic b, input int gap);
        z  = b;
        en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Start bit plus 8 data bits, MSB first.
    task automatic send_head(input logic [7:0] w, input int gap);
        logic [7:0] v;
        v = w;
        send_bit(1'b0, gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_vld", 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        en        = 1'b0;
        z         = 1'b1;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y",   32'(y),         32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_frm", 32'(frm_err),   32'd0);
        chk("rst_ovr", 32'(ovr_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: continuous strobe, A5
        send_head(8'hA5, 0);
        chk("t1_pre_vld", 32'(out_valid), 32'd0);
        send_bit(1'b1, 0);
        chk("t1_vld", 32'(out_valid), 32'd1);
        chk("t1_y",   32'(y),         32'hA5);
        chk("t1_err", {30'd0, frm_err, ovr_err}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("t1_drain_vld", 32'(out_valid), 32'd0);
        chk("t1_drain_y",   32'(y),         32'hA5);

        // 2: strobe every 4th cycle
        send_head(8'hA5, 3);
        chk("t2_pre_vld", 32'(out_valid), 32'd0);
        send_bit(1'b1, 3);
        chk("t2_vld", 32'(out_valid), 32'd1);
        chk("t2_y",   32'(y),         32'hA5);
        chk("t2_err", {30'd0, frm_err, ovr_err}, 32'd0);
        drain();

        // 3: framing error, break, recovery
        send_head(8'h3C, 0);
        send_bit(1'b0, 0);
        chk("t3_frm",  32'(frm_err),   32'd1);
        chk("t3_vld",  32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_frm_pulse", 32'(frm_err), 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 0);
        chk("t3_brk_vld", 32'(out_valid), 32'd0);
        chk("t3_brk_frm", 32'(frm_err),   32'd0);
        send_bit(1'b1, 0);
        send_head(8'h81, 0);
        send_bit(1'b1, 0);
        chk("t3_vld2", 32'(out_valid), 32'd1);
        chk("t3_y2",   32'(y),         32'h81);
        drain();

        // 4: overrun, then replacement on the drain cycle
        send_head(8'h11, 0);
        send_bit(1'b1, 0);
        chk("t4_y1", 32'(y), 32'h11);
        send_head(8'h22, 0);
        send_bit(1'b1, 0);
        chk("t4_ovr", 32'(ovr_err),   32'd1);
        chk("t4_y",   32'(y),         32'h11);
        chk("t4_vld", 32'(out_valid), 32'd1);
        chk("t4_frm", 32'(frm_err),   32'd0);
        @(posedge clk);
        #1;
        chk("t4_ovr_pulse", 32'(ovr_err), 32'd0);
        send_head(8'h22, 0);
        out_ready = 1'b1;
        send_bit(1'b1, 0);
        out_ready = 1'b0;
        chk("t4b_y",   32'(y),         32'h22);
        chk("t4b_vld", 32'(out_valid), 32'd1);
        chk("t4b_ovr", 32'(ovr_err),   32'd0);
        drain();

        // 5: async reset mid-frame
        send_head(8'h3C, 0);
        send_bit(1'b1, 0);
        chk("t5_pre_vld", 32'(out_valid), 32'd1);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_y",   32'(y),         32'd0);
        chk("t5_rst_vld", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        chk("t5_rem_vld", 32'(out_valid), 32'd0);
        send_head(8'hFF, 0);
        send_bit(1'b1, 0);
        chk("t5_vld", 32'(out_valid), 32'd1);
        chk("t5_y",   32'(y),         32'hFF);
        drain();

        // 6: back-to-back frames, consumer always ready
        out_ready = 1'b1;
        send_head(8'h00, 0);
        send_bit(1'b1, 0);
        chk("t6_vld1", 32'(out_valid), 32'd1);
        chk("t6_y1",   32'(y),         32'h00);
        send_bit(1'b0, 0);
        chk("t6_mid_vld", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        chk("t6_vld2", 32'(out_valid), 32'd1);
        chk("t6_y2",   32'(y),         32'hFF);
        chk("t6_err",  {30'd0, frm_err, ovr_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_end_vld", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Deserializer stage directly downstream of the piso serializer in the Transceiver/Serializer path. It samples the serial line one bit per enable strobe and detects start/stop framing. It reassembles DATA_WIDTH-1 data bits into a parallel word and presents the word through a one-entry valid/ready output register. Framing and overrun errors are flagged as one-cycle pulses.

Parameters:
DATA_WIDTH, 9, sets the parallel word as y[DATA_WIDTH-1:1] (default 8 data bits), matching the piso parallel width.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
en  in  1  bit-sample strobe; the line is sampled only on cycles with en=1
z  in  1  serial line; idle = 1
y  out  DATA_WIDTH-1 [DATA_WIDTH-1:1]  received parallel word, held while out_valid=1
out_valid  out  1  y holds an unconsumed word
out_ready  in  1  consumer accepts y when out_valid && out_ready
frm_err  out  1  one-cycle pulse: stop bit sampled as 0
ovr_err  out  1  one-cycle pulse: word completed while holding register full and not being drained

Behaviour:
- Reset (rst_n=0, async): state=IDLE, bit counter=0, shift register=0, y=0, out_valid=0, frm_err=0, ovr_err=0. Reset mid-frame discards the partial frame. The first frame after reset release needs a fresh start bit.
- Frame on z, sampled only on en=1: start bit 0, then DATA_WIDTH-1 data bits MSB first (the first data bit lands in y[DATA_WIDTH-1]), then stop bit 1.
- FSM states: IDLE, DATA, STOP, BREAK.
- IDLE: en && z==0 -> DATA, counter=0. en && z==1 -> stay in IDLE.
- DATA: en -> shift z into the shift register LSB side, counter+1. After DATA_WIDTH-1 data samples -> STOP. en=0 -> hold all state.
- STOP: en && z==1 -> frame good, go to IDLE. en && z==0 -> frm_err=1 for exactly one cycle, discard the word, go to BREAK.
- BREAK: wait for en && z==1, then go to IDLE. A 0 held on the line never produces a frame.
- Good-frame commit, on the clock edge where the stop bit is sampled:
  - out_valid=0, or out_valid && out_ready in that same cycle: y <= shifted word, out_valid <= 1, visible the next cycle. Latency is one clk from the stop-bit sample edge to out_valid.
  - out_valid=1 && out_ready=0: ovr_err=1 for one cycle. The new word is dropped and y keeps the old word.
- Handshake: out_valid && out_ready with no commit in that cycle -> out_valid <= 0 next cycle. y is not cleared and keeps its last value. y changes only on commit.
- frm_err and ovr_err are registered pulses, asserted the cycle after the offending sample edge. They can never both be 1 in the same cycle.
- Back-to-back frames: a start bit may be sampled on the first en strobe after the stop bit, with no idle gap required.

Decomposition:
- Shared package (transceiver_pkg): FSM state encoding (IDLE, DATA, STOP, BREAK, 2 bits) and frame constants (START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1).
- The same package is used by the piso so both ends agree on framing.
- One natural sub-module: sipo_out_reg, the one-entry valid/ready holding register containing the commit, drain and overrun logic.
- The FSM, counter and shift register stay in sipo_rx.

Test Plan:
- en=1 constantly, z sends 0,1,0,1,0,0,1,0,1,1 -> y=8'hA5 (10100101) and out_valid=1 one cycle after the stop sample. With out_ready=1 the following cycle, out_valid=0 next cycle.
- en high every 4th cycle, same frame with z held 4 cycles per bit -> y=8'hA5. out_valid rises only after the 10th strobe. No errors.
- Frame 8'h3C with stop bit 0 -> frm_err one-cycle pulse, out_valid stays 0. Line held 0 for 5 strobes, then 1, then frame 8'h81 -> y=8'h81.
- out_ready=0, frames 8'h11 then 8'h22 -> y=8'h11 stays valid, ovr_err pulses at the second stop. Repeat with out_ready=1 on the second stop cycle -> y=8'h22, no ovr_err.
- rst_n pulled low after 4 data bits of a frame -> all outputs 0 immediately (async). After release, the remainder of that frame does not produce out_valid. The next full frame 8'hFF -> y=8'hFF.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap, out_ready=1 -> two out_valid pulses, y=8'h00 then 8'hFF, no errors.
